uart_rx_ext: RTL
================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKS_PER_TICK, default 1: clk_in cycles per oversample tick, >=1.
REQ-002 SHALL have parameter OVERSAMPLING, default 8: ticks per bit, even, >=4.
REQ-003 SHALL have parameter DATA_BITS, default 8: payload bits per frame, 5..9.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: received-word FIFO entries, power of 2, >=2.
REQ-007 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port rx_serial_in, input, 1: asynchronous serial line; idles high.
REQ-010 SHALL have port rx_data_out, output, DATA_BITS: data of the FIFO head word.
REQ-011 SHALL have port parity_err_out, output, 1: parity error flag of the head word.
REQ-012 SHALL have port frame_err_out, output, 1: stop-bit error flag of the head word.
REQ-013 SHALL have port rx_valid_out, output, 1: FIFO is non-empty.
REQ-014 SHALL have port rx_ready_in, input, 1: consumer accepts; pop when rx_valid_out and rx_ready_in are both high.
REQ-015 SHALL have port overrun_out, output, 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx_serial_in through a 2-flop synchroniser reset to 1; all sampling uses the synchronised value.
REQ-017 SHALL generate a one-cycle tick every CLKS_PER_TICK cycles, free-running.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; the FSM advances only on ticks.
REQ-019 IDLE->START on the first tick that sees synchronised line low; the tick counter clears to 0.
REQ-020 Each bit SHALL be decided by a 2-of-3 majority vote of samples at ticks OVERSAMPLING/2-1, OVERSAMPLING/2 and OVERSAMPLING/2+1 of that bit.
REQ-021 START: if the voted start bit is 1, it SHALL be treated as a false start: return to IDLE, no FIFO write.
REQ-022 DATA: SHALL shift DATA_BITS voted bits LSB first, then go to PARITY if PARITY!=0, else to STOP.
REQ-023 PARITY: parity_err = voted bit != (XOR of data) for even, or != ~(XOR of data) for odd; with PARITY=0, parity_err SHALL be 0.
REQ-024 STOP: each of the STOP_BITS voted bits SHALL be checked; any 0 sets frame_err.
REQ-025 STOP SHALL return to IDLE on the decision tick (mid-sample) of the last stop bit, so a new start edge is detected immediately after.
REQ-026 On the last stop decision tick, the word {frame_err, parity_err, data} SHALL be written to the FIFO in that same cycle; rx_valid_out rises on the next cycle.
REQ-027 If the FIFO is full at the write, the word SHALL be dropped and overrun_out pulsed high for exactly one clk_in cycle; FIFO contents are unchanged.
REQ-028 A simultaneous write and pop when full SHALL accept the write; no overrun.
REQ-029 FIFO read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and the rest are equal.
REQ-030 Head-word outputs SHALL be stable while rx_valid_out is high and rx_ready_in is low.
REQ-031 A framing-error frame SHALL still be stored, with frame_err set; there is no break detection.

Reset
REQ-032 Assertion of rst_in SHALL at once force: FSM to IDLE, tick and bit counters to 0, synchroniser to 1, FIFO empty, rx_valid_out=0, rx_data_out=0, parity_err_out=0, frame_err_out=0, overrun_out=0.
REQ-033 A frame in progress at reset SHALL be discarded; after release, reception restarts only on a new falling edge of the line.

Structure
REQ-034 A shared package uart_pkg SHALL hold the parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD), the FSM state enum and the FIFO word struct.
REQ-035 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised by width and depth; the receiver FSM stays in uart_rx_ext.

Verification (CLKS_PER_TICK=2, OVERSAMPLING=8, so one bit = 16 clk_in cycles)
REQ-036 8N1, rx_ready_in=1, bytes 0x23, 0xFF, 0x00, 0xA5 sent back-to-back -> same four words out in order, all error flags 0.
REQ-037 PARITY=1, 0xA5 sent with parity bit 0, then 0xA4 with parity bit 0 -> first word parity_err=0, second word parity_err=1.
REQ-038 STOP_BITS=2, 0x3C sent with second stop bit 0 -> word 0x3C with frame_err=1, then next frame received correctly.
REQ-039 Line low for 3 clk_in cycles then high -> no FIFO write; a following 0x55 frame is received correctly.
REQ-040 rx_ready_in=0, FIFO_DEPTH+1 frames sent -> overrun_out pulses exactly once; FIFO then drains the first FIFO_DEPTH words in order.
REQ-041 rst_in asserted during data bit 4 of a frame -> all outputs are at reset values; no word appears; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity encodings,
// receiver FSM states and the word stored per received frame.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Sized for the widest payload; narrower frames leave the top data bits zero.
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_word_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a write while full is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority-voted bits, optional parity,
// 1/2 stop bits and a small FIFO of received words with error flags.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 1,
  parameter int OVERSAMPLING  = 8,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 rx_valid_out,
  input  logic                 rx_ready_in,
  output logic                 overrun_out
);

  localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLING);
  localparam int CNT_W  = $clog2(DATA_BITS + 1);
  localparam int MID    = OVERSAMPLING / 2;
  localparam int WORD_W = $bits(rx_word_t);

  function automatic logic parity_bad(input logic bit_v, input logic [DATA_BITS-1:0] d);
    case (PARITY)
      PAR_EVEN: return bit_v != (^d);
      PAR_ODD:  return bit_v != ~(^d);
      default:  return 1'b0;
    endcase
  endfunction

  logic              line_p0, line_p1;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  rx_state_t         state;
  logic [OS_W-1:0]   os_cnt, idx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              samp_lo, samp_mid, decide, bit_end, last_stop;
  logic              vote, start_edge;
  logic              s_lo, s_mid;
  logic [DATA_BITS-1:0] shreg;
  logic              perr_r, ferr_r;
  logic              fifo_wr, fifo_full, fifo_empty, pop;
  rx_word_t          wr_word, head;
  logic [WORD_W-1:0] fifo_wdata, fifo_rdata;
  logic              unused_head;

  // Stage p0/p1: two-flop synchroniser, idles high
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
    end else begin
      line_p0 <= rx_serial_in;
      line_p1 <= line_p0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end
  assign tick = (tick_cnt == TICK_W'(CLKS_PER_TICK - 1));

  // idx is the position within the current bit of the tick being processed
  assign idx        = (os_cnt == OS_W'(OVERSAMPLING - 1)) ? '0 : os_cnt + OS_W'(1);
  assign samp_lo    = (idx == OS_W'(MID - 1));
  assign samp_mid   = (idx == OS_W'(MID));
  assign decide     = (idx == OS_W'(MID + 1));
  assign bit_end    = (idx == OS_W'(OVERSAMPLING - 1));
  assign last_stop  = (bit_cnt == CNT_W'(STOP_BITS - 1));
  assign vote       = maj3(s_lo, s_mid, line_p1);
  assign start_edge = tick && (state == ST_IDLE) && !line_p1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (tick) begin
      if (state != ST_IDLE) os_cnt <= idx;
      case (state)
        ST_IDLE: begin
          if (!line_p1) begin
            state   <= ST_START;
            os_cnt  <= '0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (decide && vote) state <= ST_IDLE;
          else if (bit_end)   state <= ST_DATA;
        end
        ST_DATA: begin
          if (decide) bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_end && bit_cnt == CNT_W'(DATA_BITS)) begin
            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_cnt <= '0;
          end
        end
        ST_PARITY: begin
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave on the mid-bit decision so the next start edge is caught early
          if (decide && last_stop) state <= ST_IDLE;
          else if (bit_end)        bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p2: sample capture, data shift and error flags
  always_ff @(posedge clk_in) begin
    if (start_edge) begin
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end
    if (tick && state != ST_IDLE) begin
      if (samp_lo)  s_lo  <= line_p1;
      if (samp_mid) s_mid <= line_p1;
      if (decide) begin
        case (state)
          ST_DATA:   shreg  <= {vote, shreg[DATA_BITS-1:1]};
          ST_PARITY: perr_r <= parity_bad(vote, shreg);
          ST_STOP:   if (!vote) ferr_r <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign fifo_wr = tick && (state == ST_STOP) && decide && last_stop;

  always_comb begin
    wr_word                      = '0;
    wr_word.data[DATA_BITS-1:0]  = shreg;
    wr_word.parity_err           = (PARITY != PAR_NONE) && perr_r;
    wr_word.frame_err            = ferr_r | ~vote;
  end

  assign fifo_wdata = wr_word;
  assign pop        = rx_valid_out && rx_ready_in;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign head         = fifo_rdata;
  assign unused_head  = ^head.data;
  assign rx_valid_out = !fifo_empty;

  // Head outputs read zero while empty so reset never exposes stale storage
  assign rx_data_out    = rx_valid_out ? head.data[DATA_BITS-1:0] : '0;
  assign parity_err_out = rx_valid_out && head.parity_err;
  assign frame_err_out  = rx_valid_out && head.frame_err;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) overrun_out <= 1'b0;
    else        overrun_out <= fifo_wr && fifo_full && !pop;
  end

endmodule
